// File: rtl/lsu_bus_initiator.sv
// Load/store bus initiator: accepts one CPU access and shapes it into a word-aligned
// memory request. It runs the request/response handshake and returns extended load data.
module lsu_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_wen,
    input  logic [2:0]  lsu_func,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic              wen_q;
    logic [2:0]        func_q;
    logic [1:0]        off_q;
    logic [29:0]       addr_q;
    logic [7:0]        wmask_q;
    logic [31:0]       wdata_q;

    logic              req_legal;
    logic [4:0]        wshift;
    logic [7:0]        shaped_mask;
    logic [31:0]       shaped_wdata;
    logic [31:0]       shifted_rdata;
    logic [31:0]       load_data;
    logic              result_load;
    logic              result_err;
    logic [31:0]       result_data;

    assign lsu_ready      = (state == IDLE);
    assign lsu_done       = (state == DONE);
    assign mem_req_valid  = (state == REQ);
    assign mem_resp_ready = (state == RESP);
    assign mem_wen        = wen_q;
    assign mem_addr       = {addr_q, 2'b00};
    assign mem_wmask      = wmask_q;
    assign mem_wdata      = wdata_q;

    // Alignment follows the access size; stores have no unsigned variants.
    always_comb begin
        req_legal = 1'b0;
        case (lsu_func)
            3'b000:  req_legal = 1'b1;
            3'b001:  req_legal = ~lsu_addr[0];
            3'b010:  req_legal = (lsu_addr[1:0] == 2'b00);
            3'b100:  req_legal = ~lsu_wen;
            3'b101:  req_legal = ~lsu_wen & ~lsu_addr[0];
            default: req_legal = 1'b0;
        endcase
    end

    assign wshift = {lsu_addr[1:0], 3'b000};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shaped_mask  = 8'h00;
        shaped_wdata = 32'h0;
        if (lsu_wen) begin
            case (lsu_func[1:0])
                2'b00: begin
                    shaped_mask  = 8'h01 << lsu_addr[1:0];
                    shaped_wdata = {24'h0, lsu_wdata[7:0]} << wshift;
                end
                2'b01: begin
                    shaped_mask  = 8'h03 << lsu_addr[1:0];
                    shaped_wdata = {16'h0, lsu_wdata[15:0]} << wshift;
                end
                default: begin
                    shaped_mask  = 8'h0F;
                    shaped_wdata = lsu_wdata;
                end
            endcase
        end
    end

    assign shifted_rdata = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (func_q)
            3'b000:  load_data = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            3'b001:  load_data = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b100:  load_data = {24'h0, shifted_rdata[7:0]};
            3'b101:  load_data = {16'h0, shifted_rdata[15:0]};
            default: load_data = shifted_rdata;
        endcase
    end

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        result_load = 1'b0;
        result_err  = 1'b0;
        result_data = 32'h0;
        unique case (state)
            IDLE: begin
                if (lsu_valid) begin
                    if (req_legal) begin
                        state_next = REQ;
                    end else begin
                        state_next  = DONE;
                        result_load = 1'b1;
                        result_err  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) state_next = RESP;
            end
            RESP: begin
                // A response arriving on the final timeout cycle still wins.
                if (mem_resp_valid) begin
                    state_next  = DONE;
                    result_load = 1'b1;
                    result_data = wen_q ? 32'h0 : load_data;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == TIMEOUT_VAL) begin
                        state_next  = DONE;
                        result_load = 1'b1;
                        result_err  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wen_q     <= 1'b0;
            func_q    <= 3'b000;
            off_q     <= 2'b00;
            addr_q    <= 30'h0;
            wmask_q   <= 8'h00;
            wdata_q   <= 32'h0;
            lsu_err   <= 1'b0;
            lsu_rdata <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && lsu_valid) begin
                wen_q   <= lsu_wen;
                func_q  <= lsu_func;
                off_q   <= lsu_addr[1:0];
                addr_q  <= lsu_addr[31:2];
                wmask_q <= shaped_mask;
                wdata_q <= shaped_wdata;
            end
            if (result_load) begin
                lsu_err   <= result_err;
                lsu_rdata <= result_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Self-checking bench for lsu_bus_initiator: directed accesses from the test plan plus
// randomized accesses, each checked against a size/offset arithmetic model.
module tb_lsu_bus_initiator;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_wen;
    logic [2:0]  lsu_func;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    lsu_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
        .lsu_func(lsu_func), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, alignment by modulo, lanes by byte shifts.
    function automatic int unsigned size_of(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit model_legal(input bit wen, input logic [2:0] f, input logic [31:0] a);
        bit known;
        known = wen ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return known && ((a % size_of(f)) == 0);
    endfunction

    function automatic logic [7:0] model_mask(input bit wen, input logic [2:0] f, input logic [31:0] a);
        int unsigned m;
        if (!wen) return 8'h00;
        m = ((1 << size_of(f)) - 1) << (a % 4);
        return m[7:0];
    endfunction

    function automatic logic [31:0] model_wdata(input bit wen, input logic [2:0] f,
                                                input logic [31:0] a, input logic [31:0] d);
        longint unsigned v;
        if (!wen) return 32'h0;
        v = (longint'(d) & ((64'd1 << (8 * size_of(f))) - 1)) << (8 * (a % 4));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] rd);
        longint unsigned mask, v;
        int unsigned sz;
        sz   = size_of(f);
        mask = (64'd1 << (8 * sz)) - 1;
        v    = (longint'(rd) >> (8 * (a % 4))) & mask;
        if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic run_txn(input string tag, input bit wen, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int req_delay, input int resp_delay);
        bit          legal;
        bit          exp_to;
        int          n;
        logic [31:0] exp_rdata;
        legal  = model_legal(wen, f, a);
        exp_to = (resp_delay >= int'(TO));
        check({tag, ".ready_idle"}, lsu_ready, 1);
        lsu_valid = 1'b1; lsu_wen = wen; lsu_func = f; lsu_addr = a; lsu_wdata = wd;
        @(negedge clk);
        lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_func = 3'($urandom);
        check({tag, ".ready_busy"}, lsu_ready, 0);
        if (!legal) begin
            check({tag, ".ill_req_valid"}, mem_req_valid, 0);
            check({tag, ".ill_done"}, lsu_done, 1);
            check({tag, ".ill_err"}, lsu_err, 1);
            check({tag, ".ill_rdata"}, lsu_rdata, 0);
            @(negedge clk);
            check({tag, ".ill_done_pulse"}, lsu_done, 0);
            check({tag, ".ill_req_after"}, mem_req_valid, 0);
            check({tag, ".ill_err_hold"}, lsu_err, 1);
            return;
        end
        for (int i = 0; i <= req_delay; i++) begin
            check({tag, ".req_valid"}, mem_req_valid, 1);
            check({tag, ".req_wen"}, mem_wen, 32'(wen));
            check({tag, ".req_addr"}, mem_addr, {a[31:2], 2'b00});
            check({tag, ".req_mask"}, mem_wmask, model_mask(wen, f, a));
            check({tag, ".req_wdata"}, mem_wdata, model_wdata(wen, f, a, wd));
            check({tag, ".req_ready_low"}, lsu_ready, 0);
            mem_req_ready  = (i == req_delay);
            mem_resp_valid = 1'($urandom);
            mem_rdata      = $urandom;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        n = exp_to ? int'(TO) : resp_delay + 1;
        for (int i = 0; i < n; i++) begin
            check({tag, ".resp_ready"}, mem_resp_ready, 1);
            check({tag, ".early_done"}, lsu_done, 0);
            mem_resp_valid = (i == resp_delay);
            mem_rdata      = (i == resp_delay) ? rd : $urandom;
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        exp_rdata = (exp_to || wen) ? 32'h0 : model_load(f, a, rd);
        check({tag, ".done"}, lsu_done, 1);
        check({tag, ".err"}, lsu_err, 32'(exp_to));
        check({tag, ".rdata"}, lsu_rdata, exp_rdata);
        @(negedge clk);
        check({tag, ".done_pulse"}, lsu_done, 0);
        check({tag, ".ready_back"}, lsu_ready, 1);
        check({tag, ".rdata_hold"}, lsu_rdata, exp_rdata);
        check({tag, ".err_hold"}, lsu_err, 32'(exp_to));
    endtask

    initial begin
        rst = 1'b1;
        lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_func = 3'b000; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.ready", lsu_ready, 1);
        check("rst.done", lsu_done, 0);
        check("rst.err", lsu_err, 0);
        check("rst.rdata", lsu_rdata, 0);
        check("rst.req_valid", mem_req_valid, 0);
        check("rst.resp_ready", mem_resp_ready, 0);
        check("rst.addr", mem_addr, 0);
        check("rst.mask", mem_wmask, 0);
        check("rst.wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn("sw",    1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         0, 0);
        run_txn("sb",    1'b1, 3'b000, 32'h8000_0013, 32'h0000_00A5, 32'h0,         0, 0);
        run_txn("sh",    1'b1, 3'b001, 32'h8000_0012, 32'h1234_CAFE, 32'h0,         1, 1);
        run_txn("lb",    1'b0, 3'b000, 32'h8000_0002, 32'h0,         32'h12F6_3456, 0, 0);
        run_txn("lbu",   1'b0, 3'b100, 32'h8000_0002, 32'h0,         32'h12F6_3456, 0, 0);
        run_txn("lhu",   1'b0, 3'b101, 32'h8000_0002, 32'h0,         32'h12F6_3456, 0, 0);
        run_txn("lh",    1'b0, 3'b001, 32'h8000_0002, 32'h0,         32'h82F6_3456, 0, 2);
        run_txn("lw_mis",1'b0, 3'b010, 32'h8000_0006, 32'h0,         32'h0,         0, 0);
        run_txn("sb_ill",1'b1, 3'b100, 32'h8000_0000, 32'h0,         32'h0,         0, 0);
        run_txn("ld_011",1'b0, 3'b011, 32'h8000_0000, 32'h0,         32'h0,         0, 0);
        run_txn("sw_to", 1'b1, 3'b010, 32'h8000_0020, 32'h0BAD_F00D, 32'h0,         5, TO);
        run_txn("lw_l8", 1'b0, 3'b010, 32'h8000_0024, 32'h0,         32'h7654_3210, 0, TO - 1);

        // Reset in the middle of a response wait drops the access.
        lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_func = 3'b010; lsu_addr = 32'h8000_0030;
        @(negedge clk);
        lsu_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstmid.in_resp", mem_resp_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.ready", lsu_ready, 1);
        check("rstmid.req_valid", mem_req_valid, 0);
        check("rstmid.resp_ready", mem_resp_ready, 0);
        check("rstmid.done", lsu_done, 0);
        mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid.late_resp_done", lsu_done, 0);
            check("rstmid.late_resp_ready", lsu_ready, 1);
        end
        mem_resp_valid = 1'b0;

        for (int t = 0; t < 40; t++) begin
            bit          w;
            logic [2:0]  f;
            logic [31:0] a;
            int          rq, rs;
            w  = 1'($urandom);
            f  = 3'($urandom_range(0, 7));
            a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            rq = $urandom_range(0, 3);
            rs = ($urandom_range(0, 9) == 0) ? int'(TO) + $urandom_range(0, 2) : $urandom_range(0, 3);
            run_txn($sformatf("rnd%0d", t), w, f, a, $urandom, $urandom, rq, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
